// File: rtl/lbus_master_pkg.sv
// lbus_master_pkg: shared definitions for the local-bus initiator.
//   - Transfer size encodings (SZ_*).
//   - FSM state encodings (ST_*).
//   - lbus_misaligned(): flags commands that must not reach the bus.
package lbus_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WR   = 2'b01;
    localparam logic [1:0] ST_RD   = 2'b10;
    localparam logic [1:0] ST_RSP  = 2'b11;

    // Also rejects the reserved size so one check covers every error case.
    function automatic logic lbus_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lbus_lane.sv
// lbus_lane: combinational byte-lane steering for the local-bus initiator.
// Optional feature macro: LBUS_MST_SEXT_EN (adds sign_ext input for signed byte/half reads).
// Ports:
//   size      in   transfer size (SZ_*)
//   offset    in   byte offset within the word
//   wdata_in  in   right-aligned write data
//   rdata_in  in   raw bus read data
//   sign_ext  in   sign-extend byte/half reads (only with LBUS_MST_SEXT_EN)
//   we_lanes  out  byte write enables
//   wdata_out out  write data replicated across lanes
//   rdata_out out  read data shifted down and extended to size
module lbus_lane #(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [XLEN-1:0] rdata_in,
`ifdef LBUS_MST_SEXT_EN
    input  logic            sign_ext,
`endif
    output logic [3:0]      we_lanes,
    output logic [XLEN-1:0] wdata_out,
    output logic [XLEN-1:0] rdata_out
);
    import lbus_master_pkg::*;

    logic            ext;
    logic [XLEN-1:0] shifted;

`ifdef LBUS_MST_SEXT_EN
    assign ext = sign_ext;
`else
    assign ext = 1'b0;
`endif

    assign shifted = rdata_in >> {offset, 3'b000};

    always_comb begin
        we_lanes  = 4'b0000;
        wdata_out = wdata_in;
        rdata_out = '0;
        case (size)
            SZ_BYTE: begin
                we_lanes  = 4'b0001 << offset;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{(XLEN-8){ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                we_lanes  = offset[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{(XLEN-16){ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                we_lanes  = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = shifted;
            end
            default: begin
                we_lanes  = 4'b0000;
                wdata_out = wdata_in;
                rdata_out = '0;
            end
        endcase
    end

endmodule

// File: rtl/lbus_master.sv
// lbus_master: local-bus initiator. Converts a valid/ready command stream into single
// sel/addr/we/wdata bus cycles and returns read data or write completion on a valid/ready
// response stream. One command outstanding at a time.
// Optional feature macro: LBUS_MST_SEXT_EN (adds cmd_signed for sign-extended byte/half reads).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only when idle
//   cmd_write            1 = write, 0 = read
//   cmd_size             00 byte, 01 half, 10 word, 11 reserved
//   cmd_addr             byte address (AWIDTH+2 bits)
//   cmd_wdata            right-aligned write data
//   cmd_signed           sign-extend byte/half reads (only with LBUS_MST_SEXT_EN)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extracted read data, 0 for writes and errors
//   rsp_err              misaligned or reserved-size command
//   sel, addr, we, wdata registered local-bus outputs
//   rdata                bus read data
module lbus_master #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [AWIDTH+1:0] cmd_addr,
    input  logic [XLEN-1:0]   cmd_wdata,
`ifdef LBUS_MST_SEXT_EN
    input  logic              cmd_signed,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              sel,
    output logic [AWIDTH-1:0] addr,
    output logic [3:0]        we,
    output logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata
);
    import lbus_master_pkg::*;

    if (XLEN != 32) begin : g_xlen_check
        $error("lbus_master: XLEN must be 32");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("lbus_master: RD_LAT must be in 1..4");
    end

    localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0]      state;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic [1:0]      rd_cnt;
    logic            sext_q;
    logic            accept;
    logic            bad_cmd;
    logic [1:0]      lane_size;
    logic [1:0]      lane_off;
    logic [3:0]      lane_we;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign bad_cmd   = lbus_misaligned(cmd_size, cmd_addr[1:0]);

    // The lane block serves both paths: live command fields steer write lanes at accept,
    // the captured fields steer read extraction while the bus cycle is in flight.
    assign lane_size = (state == ST_IDLE) ? cmd_size : size_q;
    assign lane_off  = (state == ST_IDLE) ? cmd_addr[1:0] : off_q;

    lbus_lane #(
        .XLEN(XLEN)
    ) u_lane (
        .size      (lane_size),
        .offset    (lane_off),
        .wdata_in  (cmd_wdata),
        .rdata_in  (rdata),
`ifdef LBUS_MST_SEXT_EN
        .sign_ext  (sext_q),
`endif
        .we_lanes  (lane_we),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            size_q    <= SZ_BYTE;
            off_q     <= 2'b00;
            rd_cnt    <= 2'b00;
            sext_q    <= 1'b0;
            sel       <= 1'b0;
            we        <= 4'b0000;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q    <= cmd_size;
                        off_q     <= cmd_addr[1:0];
`ifdef LBUS_MST_SEXT_EN
                        sext_q    <= cmd_signed;
`else
                        sext_q    <= 1'b0;
`endif
                        rsp_rdata <= '0;
                        rsp_err   <= bad_cmd;
                        if (bad_cmd) begin
                            // Rejected commands never touch the bus.
                            rsp_valid <= 1'b1;
                            state     <= ST_RSP;
                        end else begin
                            addr  <= cmd_addr[AWIDTH+1:2];
                            wdata <= lane_wdata;
                            sel   <= 1'b1;
                            if (cmd_write) begin
                                we    <= lane_we;
                                state <= ST_WR;
                            end else begin
                                we     <= 4'b0000;
                                rd_cnt <= RD_CNT_INIT;
                                state  <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: begin
                    sel       <= 1'b0;
                    we        <= 4'b0000;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RD: begin
                    if (rd_cnt == 2'b00) begin
                        rsp_rdata <= lane_rdata;
                        sel       <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
